ccl_label_assign: RTL and testbench
===================================

// Module: ccl_label_assign
// PURPOSE
//  Pixel-rate label assignment for connected-component labelling of the binary fish mask.
//  Consumes each pixel plus the label of the pixel directly above, delivered by shift_11x720.
//  Produces this pixel's label and the shift/sel/data controls that write it into shift_11x720.
//  Reports label-equivalence (merge) events to the downstream equivalence table.
// PARAMETERS
//  LBL_W   11   label width; label 0 = background
//  LINE_W  720  active pixels per line; column counter wraps at LINE_W-1
//  MAX_LBL 2**LBL_W-1  highest assignable label (2047)
// PORTS
//  clk          in   1      single clock, rising edge
//  reset_n      in   1      synchronous, active-low reset
//  frame_start  in   1      1-cycle pulse before first pixel of a frame
//  pix_valid    in   1      pixel strobe; gaps allowed
//  pix_bin      in   1      binary mask value of the pixel
//  label_up     in   LBL_W  label of pixel above (shift_11x720 sr_out_720), valid with pix_valid
//  shift        out  1      shift enable to shift_11x720
//  sel          out  1      0: lbl_new selected, 1: lbl_inh selected
//  lbl_new      out  LBL_W  freshly allocated label (drives sr_in_0)
//  lbl_inh      out  LBL_W  inherited label or 0 for background (drives sr_in_1)
//  merge_valid  out  1      equivalence event strobe
//  merge_hi     out  LBL_W  larger label of the merged pair
//  merge_lo     out  LBL_W  smaller label of the merged pair
//  lbl_count    out  LBL_W  last label allocated in current frame
//  lbl_ovf      out  1      sticky: label space exhausted this frame
//  eol          out  1      pulse with the output of the last pixel of a line
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): all outputs 0; next label=1; column=0; left label=0; ovf=0.
//  - Latency 1: pixel at cycle N -> shift=1 with sel/lbl_new/lbl_inh/merge at N+1.
//  - shift=1 exactly one cycle per pix_valid; shift=0 otherwise; other outputs hold.
//  - L = label output for previous pixel on this line (0 at column 0); U = label_up.
//  - Decision for a pixel:
//      pix_bin=0         -> sel=1, lbl_inh=0
//      L=0,U=0           -> sel=0, lbl_new=next label; next label increments
//      one nonzero       -> sel=1, lbl_inh=nonzero one
//      both nonzero,L==U -> sel=1, lbl_inh=L
//      both nonzero,L!=U -> sel=1, lbl_inh=min; merge_valid=1, hi=max, lo=min
//  - Back-to-back pixels: L taken from the label issued the previous cycle (internal bypass).
//  - Column counter advances per pix_valid; at LINE_W-1 eol=1 next cycle, column->0, L->0.
//  - Exhaustion: allocation when next label=MAX_LBL issues MAX_LBL and sets lbl_ovf;
//    later allocations reuse MAX_LBL (saturate), no wrap to 0.
//  - frame_start: next label->1, column->0, L->0, lbl_ovf->0, lbl_count->0; a pixel in the
//    same cycle belongs to the new frame (column 0).
//  - reset_n low mid-line: pending pixel dropped, no shift issued, state as reset.
// CONFIGURATION
//  CCL_DIAG_EN defined: 8-connectivity; add UL = label_up registered at previous pixel
//    (0 at column 0); label = min of nonzero {L,U,UL}; merges of distinct nonzero labels
//    issued as pairs (max,min), at most one per cycle: the larger pair, smaller held in
//    lbl_inh only. merge_* width unchanged.
//  Undefined: 4-connectivity (L,U) only; no UL register.
// STRUCTURE
//  Package ccl_pkg: LBL_W, LINE_W, MAX_LBL, BG_LABEL=0, typedef label_t.
//  Sub-module ccl_nbr_resolve: combinational min/merge decision from L,U(,UL), pix_bin.
//  Top holds column counter, label allocator, left/UL registers, output registers.
// TESTING
//  1 Reset then single pixel bin=1,U=0 at col 0 -> next cycle shift=1,sel=0,lbl_new=1.
//  2 Run bin=1 x3,U=0 -> labels 1,1,1 (sel=0 then sel=1,lbl_inh=1); lbl_count=1.
//  3 L=3,U=5 bin=1 -> lbl_inh=3, merge_valid=1, merge_hi=5, merge_lo=3, one cycle.
//  4 720 pixels, last bin=1 -> eol=1 with it; pixel 721 bin=1,U=0 gets new label (L cleared).
//  5 Force next label=2047, two isolated blobs -> both 2047, lbl_ovf=1; frame_start clears, next=1.
//  6 pix_valid gaps + reset_n low mid-line -> no extra shift; outputs 0; first pixel after gets 1.

Source files
------------

// File: rtl/ccl_pkg.sv
// Shared types and constants for connected-component label assignment.
// Optional build macro: CCL_DIAG_EN (8-connectivity, consumed by the resolver and top).
package ccl_pkg;

   localparam int LBL_W  = 11;
   localparam int LINE_W = 720;

   typedef logic [LBL_W-1:0] label_t;

   localparam label_t MAX_LBL  = label_t'((2 ** LBL_W) - 1);
   localparam label_t BG_LABEL = '0;

   function automatic label_t lbl_min(input label_t a, input label_t b);
      return (a < b) ? a : b;
   endfunction

   function automatic label_t lbl_max(input label_t a, input label_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ccl_label_assign_if.sv
// Pixel-in / label-out bundle between the pixel source and the label assigner.
// Signal set is identical with or without CCL_DIAG_EN.
interface ccl_label_assign_if
   import ccl_pkg::*;
;
   logic   frame_start;
   logic   pix_valid;
   logic   pix_bin;
   label_t label_up;

   logic   shift;
   logic   sel;
   label_t lbl_new;
   label_t lbl_inh;
   logic   merge_valid;
   label_t merge_hi;
   label_t merge_lo;
   label_t lbl_count;
   logic   lbl_ovf;
   logic   eol;

   modport master (
      output frame_start, pix_valid, pix_bin, label_up,
      input  shift, sel, lbl_new, lbl_inh, merge_valid, merge_hi, merge_lo,
             lbl_count, lbl_ovf, eol
   );

   modport slave (
      input  frame_start, pix_valid, pix_bin, label_up,
      output shift, sel, lbl_new, lbl_inh, merge_valid, merge_hi, merge_lo,
             lbl_count, lbl_ovf, eol
   );

endinterface

// File: rtl/ccl_nbr_resolve.sv
// Combinational neighbour resolution: decides allocate / inherit / merge for one pixel.
// CCL_DIAG_EN adds the upper-left neighbour (8-connectivity); when three distinct
// labels meet, the merge reported is (largest, middle) and the pixel takes the minimum.
module ccl_nbr_resolve
   import ccl_pkg::*;
(
   input  logic   pix_bin_i,
   input  label_t lbl_l_i,
   input  label_t lbl_u_i,
`ifdef CCL_DIAG_EN
   input  label_t lbl_ul_i,
`endif
   output logic   alloc_o,
   output label_t lbl_inh_o,
   output logic   merge_o,
   output label_t merge_hi_o,
   output label_t merge_lo_o
);

`ifdef CCL_DIAG_EN
   label_t s0, s1, s2, tmp, min_nz;

   // Sort the three neighbours ascending, then pick min nonzero and the top merge pair.
   always_comb begin
      s0 = lbl_l_i;
      s1 = lbl_u_i;
      s2 = lbl_ul_i;
      tmp = BG_LABEL;
      if (s0 > s1) begin tmp = s0; s0 = s1; s1 = tmp; end
      if (s1 > s2) begin tmp = s1; s1 = s2; s2 = tmp; end
      if (s0 > s1) begin tmp = s0; s0 = s1; s1 = tmp; end
      min_nz = (s0 != BG_LABEL) ? s0 : ((s1 != BG_LABEL) ? s1 : s2);

      alloc_o    = 1'b0;
      lbl_inh_o  = BG_LABEL;
      merge_o    = 1'b0;
      merge_hi_o = BG_LABEL;
      merge_lo_o = BG_LABEL;
      if (pix_bin_i) begin
         if (s2 == BG_LABEL) begin
            alloc_o = 1'b1;
         end else begin
            lbl_inh_o = min_nz;
            if (s2 != min_nz) begin
               merge_o    = 1'b1;
               merge_hi_o = s2;
               merge_lo_o = ((s1 != BG_LABEL) && (s1 != s2)) ? s1 : min_nz;
            end
         end
      end
   end
`else
   // Left/up only: allocate on isolated pixel, inherit the smaller nonzero, merge on conflict.
   always_comb begin
      alloc_o    = 1'b0;
      lbl_inh_o  = BG_LABEL;
      merge_o    = 1'b0;
      merge_hi_o = BG_LABEL;
      merge_lo_o = BG_LABEL;
      if (pix_bin_i) begin
         if ((lbl_l_i == BG_LABEL) && (lbl_u_i == BG_LABEL)) begin
            alloc_o = 1'b1;
         end else if (lbl_l_i == BG_LABEL) begin
            lbl_inh_o = lbl_u_i;
         end else if (lbl_u_i == BG_LABEL) begin
            lbl_inh_o = lbl_l_i;
         end else begin
            lbl_inh_o = lbl_min(lbl_l_i, lbl_u_i);
            if (lbl_l_i != lbl_u_i) begin
               merge_o    = 1'b1;
               merge_hi_o = lbl_max(lbl_l_i, lbl_u_i);
               merge_lo_o = lbl_min(lbl_l_i, lbl_u_i);
            end
         end
      end
   end
`endif

endmodule

// File: rtl/ccl_label_assign.sv
// Pixel-rate label assigner: column counter, label allocator, left (and UL) neighbour
// registers and registered outputs, one cycle of latency per pixel.
// Build macro: CCL_DIAG_EN enables 8-connectivity via an upper-left label register.
module ccl_label_assign
   import ccl_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   ccl_label_assign_if.slave bus_if
);

   localparam int               COL_W    = $clog2(LINE_W);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);

   logic [COL_W-1:0] col_q, col_d, col_eff;
   label_t next_q, next_d, next_eff;
   label_t left_q, left_d, left_eff;
   label_t count_q, count_d, count_eff;
   logic   ovf_q, ovf_d, ovf_eff;
   logic   shift_q, shift_d, sel_q, sel_d, mv_q, mv_d, eol_q, eol_d;
   label_t new_q, new_d, inh_q, inh_d, hi_q, hi_d, lo_q, lo_d;
   logic   r_alloc, r_merge, last_col;
   label_t r_inh, r_hi, r_lo, pix_lbl;

   // A frame_start pixel sees a fresh frame, so per-frame state is overridden in the same cycle.
   assign col_eff   = bus_if.frame_start ? '0 : col_q;
   assign next_eff  = bus_if.frame_start ? label_t'(1) : next_q;
   assign left_eff  = bus_if.frame_start ? BG_LABEL : left_q;
   assign count_eff = bus_if.frame_start ? BG_LABEL : count_q;
   assign ovf_eff   = bus_if.frame_start ? 1'b0 : ovf_q;
   assign last_col  = (col_eff == COL_LAST);

`ifdef CCL_DIAG_EN
   label_t ul_q, ul_d, ul_eff;
   assign ul_eff = bus_if.frame_start ? BG_LABEL : ul_q;
`endif

   ccl_nbr_resolve u_resolve (
      .pix_bin_i  (bus_if.pix_bin),
      .lbl_l_i    (left_eff),
      .lbl_u_i    (bus_if.label_up),
`ifdef CCL_DIAG_EN
      .lbl_ul_i   (ul_eff),
`endif
      .alloc_o    (r_alloc),
      .lbl_inh_o  (r_inh),
      .merge_o    (r_merge),
      .merge_hi_o (r_hi),
      .merge_lo_o (r_lo)
   );

   // Next-state: allocate or inherit per pixel; left label is bypassed from this decision.
   always_comb begin
      col_d   = col_eff;
      next_d  = next_eff;
      left_d  = left_eff;
      count_d = count_eff;
      ovf_d   = ovf_eff;
      shift_d = 1'b0;
      mv_d    = 1'b0;
      eol_d   = 1'b0;
      sel_d   = sel_q;
      new_d   = new_q;
      inh_d   = inh_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      pix_lbl = BG_LABEL;
`ifdef CCL_DIAG_EN
      ul_d    = ul_eff;
`endif
      if (bus_if.pix_valid) begin
         shift_d = 1'b1;
         eol_d   = last_col;
         if (r_alloc) begin
            sel_d   = 1'b0;
            new_d   = next_eff;
            count_d = next_eff;
            pix_lbl = next_eff;
            // Label space saturates at MAX_LBL rather than wrapping into background.
            if (next_eff == MAX_LBL) ovf_d = 1'b1;
            else                     next_d = next_eff + label_t'(1);
         end else begin
            sel_d   = 1'b1;
            inh_d   = r_inh;
            pix_lbl = r_inh;
            if (r_merge) begin
               mv_d = 1'b1;
               hi_d = r_hi;
               lo_d = r_lo;
            end
         end
         col_d  = last_col ? '0 : col_eff + COL_W'(1);
         left_d = last_col ? BG_LABEL : pix_lbl;
`ifdef CCL_DIAG_EN
         ul_d   = last_col ? BG_LABEL : bus_if.label_up;
`endif
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         col_q   <= '0;
         next_q  <= label_t'(1);
         left_q  <= BG_LABEL;
         count_q <= BG_LABEL;
         ovf_q   <= 1'b0;
         shift_q <= 1'b0;
         sel_q   <= 1'b0;
         mv_q    <= 1'b0;
         eol_q   <= 1'b0;
         new_q   <= BG_LABEL;
         inh_q   <= BG_LABEL;
         hi_q    <= BG_LABEL;
         lo_q    <= BG_LABEL;
`ifdef CCL_DIAG_EN
         ul_q    <= BG_LABEL;
`endif
      end else begin
         col_q   <= col_d;
         next_q  <= next_d;
         left_q  <= left_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         shift_q <= shift_d;
         sel_q   <= sel_d;
         mv_q    <= mv_d;
         eol_q   <= eol_d;
         new_q   <= new_d;
         inh_q   <= inh_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifdef CCL_DIAG_EN
         ul_q    <= ul_d;
`endif
      end
   end

   assign bus_if.shift       = shift_q;
   assign bus_if.sel         = sel_q;
   assign bus_if.lbl_new     = new_q;
   assign bus_if.lbl_inh     = inh_q;
   assign bus_if.merge_valid = mv_q;
   assign bus_if.merge_hi    = hi_q;
   assign bus_if.merge_lo    = lo_q;
   assign bus_if.lbl_count   = count_q;
   assign bus_if.lbl_ovf     = ovf_q;
   assign bus_if.eol         = eol_q;

endmodule

// File: tb/tb_ccl_label_assign.sv
// Self-checking bench for ccl_label_assign (4-connectivity build, CCL_DIAG_EN undefined).
module tb_ccl_label_assign;
   import ccl_pkg::*;

   localparam int MAXL = (2 ** LBL_W) - 1;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   ccl_label_assign_if bus_if ();

   ccl_label_assign dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus_if  (bus_if.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame-level rules evaluated per accepted pixel.
   int m_next = 1, m_col = 0, m_left = 0;
   bit chk_en = 0, exp_rst = 0, exp_shift = 0, exp_sel = 0, exp_merge = 0, exp_eol = 0, exp_ovf = 0;
   int exp_lbl = 0, exp_hi = 0, exp_lo = 0, exp_cnt = 0;

   always @(posedge clk) begin : model
      int L, U, lbl;
      if (!reset_n) begin
         chk_en = 1; exp_rst = 1;
         m_next = 1; m_col = 0; m_left = 0;
         exp_shift = 0; exp_merge = 0; exp_eol = 0; exp_ovf = 0; exp_cnt = 0;
      end else begin
         exp_rst = 0; exp_shift = 0; exp_merge = 0; exp_eol = 0;
         if (bus_if.frame_start) begin
            m_next = 1; m_col = 0; m_left = 0; exp_cnt = 0; exp_ovf = 0;
         end
         if (bus_if.pix_valid) begin
            L = m_left;
            U = int'(bus_if.label_up);
            exp_shift = 1;
            exp_eol = (m_col == LINE_W - 1);
            if (!bus_if.pix_bin) begin
               exp_sel = 1; lbl = 0;
            end else if (L == 0 && U == 0) begin
               exp_sel = 0; lbl = m_next; exp_cnt = m_next;
               if (m_next == MAXL) exp_ovf = 1;
               else m_next = m_next + 1;
            end else if (L == 0 || U == 0) begin
               exp_sel = 1; lbl = L + U;
            end else begin
               exp_sel = 1; lbl = (L < U) ? L : U;
               if (L != U) begin
                  exp_merge = 1; exp_hi = (L > U) ? L : U; exp_lo = lbl;
               end
            end
            exp_lbl = lbl;
            m_left = exp_eol ? 0 : lbl;
            m_col = (m_col + 1) % LINE_W;
         end
      end
   end

   // Compare process: outputs are stable on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("shift", int'(bus_if.shift), int'(exp_shift));
         chk("eol", int'(bus_if.eol), int'(exp_eol));
         chk("merge_valid", int'(bus_if.merge_valid), int'(exp_merge));
         chk("lbl_count", int'(bus_if.lbl_count), exp_cnt);
         chk("lbl_ovf", int'(bus_if.lbl_ovf), int'(exp_ovf));
         if (exp_rst) begin
            chk("rst_sel", int'(bus_if.sel), 0);
            chk("rst_lbl_new", int'(bus_if.lbl_new), 0);
            chk("rst_lbl_inh", int'(bus_if.lbl_inh), 0);
            chk("rst_merge_hi", int'(bus_if.merge_hi), 0);
            chk("rst_merge_lo", int'(bus_if.merge_lo), 0);
         end
         if (exp_shift) begin
            chk("sel", int'(bus_if.sel), int'(exp_sel));
            if (exp_sel) chk("lbl_inh", int'(bus_if.lbl_inh), exp_lbl);
            else         chk("lbl_new", int'(bus_if.lbl_new), exp_lbl);
         end
         if (exp_merge) begin
            chk("merge_hi", int'(bus_if.merge_hi), exp_hi);
            chk("merge_lo", int'(bus_if.merge_lo), exp_lo);
         end
      end
   end

   // Drive one cycle of inputs from a falling edge and advance to the next falling edge.
   task automatic step(input bit fs, input bit pv, input bit bin, input int up, input bit rn = 1'b1);
      reset_n            = rn;
      bus_if.frame_start = fs;
      bus_if.pix_valid   = pv;
      bus_if.pix_bin     = bin;
      bus_if.label_up    = label_t'(up);
      @(negedge clk);
   endtask

   initial begin
      bit b;
      bus_if.frame_start = 0; bus_if.pix_valid = 0; bus_if.pix_bin = 0; bus_if.label_up = '0;

      // Reset
      step(0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      chk("t0_shift", int'(bus_if.shift), 0);
      chk("t0_count", int'(bus_if.lbl_count), 0);

      // Single pixel at column 0
      step(0, 1, 1, 0);
      chk("t1_shift", int'(bus_if.shift), 1);
      chk("t1_sel", int'(bus_if.sel), 0);
      chk("t1_lbl_new", int'(bus_if.lbl_new), 1);

      // Run of three foreground pixels
      step(0, 1, 1, 0);
      chk("t2_sel", int'(bus_if.sel), 1);
      chk("t2_inh_a", int'(bus_if.lbl_inh), 1);
      step(0, 1, 1, 0);
      chk("t2_inh_b", int'(bus_if.lbl_inh), 1);
      chk("t2_count", int'(bus_if.lbl_count), 1);

      // Merge with L=3, U=5
      step(1, 0, 0, 0);
      step(0, 1, 1, 0); step(0, 1, 0, 0);
      step(0, 1, 1, 0); step(0, 1, 0, 0);
      step(0, 1, 1, 0);
      chk("t3_lbl3", int'(bus_if.lbl_new), 3);
      step(0, 1, 1, 5);
      chk("t3_inh", int'(bus_if.lbl_inh), 3);
      chk("t3_mv", int'(bus_if.merge_valid), 1);
      chk("t3_hi", int'(bus_if.merge_hi), 5);
      chk("t3_lo", int'(bus_if.merge_lo), 3);
      step(0, 0, 0, 0);
      chk("t3_mv_pulse", int'(bus_if.merge_valid), 0);

      // Full line, eol on pixel 720, then left label cleared
      step(1, 0, 0, 0);
      for (int i = 0; i < LINE_W; i++) begin
         b = (i == LINE_W - 1) ? 1'b1 : 1'($urandom_range(0, 1));
         step(0, 1, b, 0);
      end
      chk("t4_eol", int'(bus_if.eol), 1);
      step(0, 1, 1, 0);
      chk("t4_newline_sel", int'(bus_if.sel), 0);
      chk("t4_eol_pulse", int'(bus_if.eol), 0);

      // Label exhaustion
      step(1, 0, 0, 0);
      for (int k = 1; k < MAXL; k++) begin
         step(0, 1, 1, 0);
         step(0, 1, 0, 0);
      end
      chk("t5_count_pre", int'(bus_if.lbl_count), MAXL - 1);
      chk("t5_ovf_pre", int'(bus_if.lbl_ovf), 0);
      step(0, 1, 1, 0);
      chk("t5_new_max", int'(bus_if.lbl_new), MAXL);
      chk("t5_ovf", int'(bus_if.lbl_ovf), 1);
      step(0, 1, 0, 0);
      step(0, 1, 1, 0);
      chk("t5_new_sat", int'(bus_if.lbl_new), MAXL);
      chk("t5_ovf_sticky", int'(bus_if.lbl_ovf), 1);
      step(1, 0, 0, 0);
      chk("t5_fs_count", int'(bus_if.lbl_count), 0);
      chk("t5_fs_ovf", int'(bus_if.lbl_ovf), 0);
      step(0, 1, 1, 0);
      chk("t5_fs_new", int'(bus_if.lbl_new), 1);

      // Gaps and mid-line reset
      step(0, 0, 0, 0);
      chk("t6_gap", int'(bus_if.shift), 0);
      step(0, 1, 1, 0);
      chk("t6_inh", int'(bus_if.lbl_inh), 1);
      step(0, 1, 1, 0, 0);
      chk("t6_rst_shift", int'(bus_if.shift), 0);
      chk("t6_rst_inh", int'(bus_if.lbl_inh), 0);
      step(0, 0, 0, 0);
      step(0, 1, 1, 0);
      chk("t6_after_sel", int'(bus_if.sel), 0);
      chk("t6_after_new", int'(bus_if.lbl_new), 1);

      // Randomised traffic against the model
      for (int n = 0; n < 6000; n++) begin
         step(1'($urandom_range(0, 499) == 0),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6)),
              1'($urandom_range(0, 1999) != 0));
      end
      step(0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
